// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one-entry skid buffer for decode
// back-pressure, and redirect handling with stale-response discard.
module fetch_unit #(
  parameter int               Width    = 32,
  parameter logic [Width-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [Width-1:0] imem_addr,
  output logic             imem_req,
  input  logic [Width-1:0] imem_rdata,
  input  logic             imem_ready,
  input  logic             stall,
  input  logic             redirect,
  input  logic             redirect_sel,
  input  logic [Width-1:0] branch_pc,
  input  logic [Width-1:0] ImmOp,
  input  logic [Width-1:0] alu_result,
  output logic [Width-1:0] instr_out,
  output logic [Width-1:0] pc_out,
  output logic [Width-1:0] pc_plus4_out,
  output logic             instr_valid
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD
  } state_t;

  localparam logic [Width-1:0] NOP  = Width'(32'h0000_0013);
  localparam logic [Width-1:0] FOUR = Width'(4);

  state_t           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic [Width-1:0] instr_d, pco_d, p4_d;
  logic             valid_d;
  logic [Width-1:0] skid_instr_q, skid_instr_d;
  logic [Width-1:0] skid_pc_q, skid_pc_d;
  logic [Width-1:0] target, pc_inc;

  assign target = redirect_sel ? {alu_result[Width-1:1], 1'b0}
                               : branch_pc + ImmOp;
  assign pc_inc = pc_q + FOUR;

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_out;
    pco_d        = pc_out;
    p4_d         = pc_plus4_out;
    valid_d      = instr_valid;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (redirect) begin
      // Redirect beats stall; any response this cycle is dropped.
      valid_d      = 1'b0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      pc_d         = target;
      unique case (state_q)
        FETCH:   state_d = imem_ready ? FETCH : DISCARD;
        HOLD:    state_d = FETCH;
        default: state_d = DISCARD;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc_inc;
            if (!instr_valid || !stall) begin
              instr_d = imem_rdata;
              pco_d   = pc_q;
              p4_d    = pc_inc;
              valid_d = 1'b1;
            end else begin
              skid_instr_d = imem_rdata;
              skid_pc_d    = pc_q;
              state_d      = HOLD;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            instr_d      = skid_instr_q;
            pco_d        = skid_pc_q;
            p4_d         = skid_pc_q + FOUR;
            valid_d      = 1'b1;
            skid_instr_d = '0;
            skid_pc_d    = '0;
            state_d      = FETCH;
          end
        end
        DISCARD: begin
          if (imem_ready) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      instr_out    <= NOP;
      pc_out       <= '0;
      pc_plus4_out <= '0;
      instr_valid  <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_out    <= instr_d;
      pc_out       <= pco_d;
      pc_plus4_out <= p4_d;
      instr_valid  <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a random run scored
// against an in-order instruction-stream reference.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_req, imem_ready;
  logic        stall, redirect, redirect_sel;
  logic [31:0] branch_pc, ImmOp, alu_result;
  logic [31:0] instr_out, pc_out, pc_plus4_out;
  logic        instr_valid;

  logic [31:0] addr2, rdata2, instr2, pc2, p42;
  logic        req2, v2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // Memory only returns real data against a live request.
  always_comb imem_rdata = imem_req ? mem_f(imem_addr) : 32'hDEAD_BEEF;
  always_comb rdata2 = mem_f(addr2);

  fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .stall(stall), .redirect(redirect),
    .redirect_sel(redirect_sel), .branch_pc(branch_pc),
    .ImmOp(ImmOp), .alu_result(alu_result),
    .instr_out(instr_out), .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out), .instr_valid(instr_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_addr(addr2), .imem_req(req2),
    .imem_rdata(rdata2), .imem_ready(1'b1),
    .stall(1'b0), .redirect(1'b0),
    .redirect_sel(1'b0), .branch_pc(32'h0),
    .ImmOp(32'h0), .alu_result(32'h0),
    .instr_out(instr2), .pc_out(pc2),
    .pc_plus4_out(p42), .instr_valid(v2)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_sel = 1'b0;
    branch_pc = '0;
    ImmOp = '0;
    alu_result = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] exp_pc, tgt;
  logic [31:0] p_instr, p_pc, p_addr, p_tgt;
  logic        p_hold, p_redir, p_wait, done;
  int          idle;

  initial begin
    // Reset state and zero-wait streaming (also the wrapping instance)
    do_reset();
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr_out, 32'h13);
    check("rst_pc", pc_out, 0);
    check("rst_p4", pc_plus4_out, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_req", imem_req, 1);
    check("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("seq_valid", instr_valid, 1);
      check("seq_pc", pc_out, 32'(i * 4));
      check("seq_instr", instr_out, mem_f(32'(i * 4)));
      check("seq_addr", imem_addr, 32'((i + 1) * 4));
      if (i == 0) begin
        check("wrap_pc", pc2, 32'hFFFF_FFFC);
        check("wrap_p4", p42, 0);
        check("wrap_addr", addr2, 0);
      end
      if (i == 1) check("wrap_pc2", pc2, 0);
    end

    // Stall for three cycles while PC 8 returns
    do_reset();
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_pc", pc_out, 4);
      check("stall_req", imem_req, 0);
      check("stall_valid", instr_valid, 1);
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("release_pc", pc_out, 32'(8 + 4 * k));
      check("release_instr", instr_out, mem_f(32'(8 + 4 * k)));
    end

    // Asynchronous reset while holding
    do_reset();
    imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    stall = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", instr_valid, 0);
    check("arst_instr", instr_out, 32'h13);
    check("arst_pc", pc_out, 0);
    check("arst_addr", imem_addr, 0);
    check("arst_req", imem_req, 1);
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    check("arst_first_pc", pc_out, 0);

    // Branch redirect with response in flight
    do_reset();
    imem_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b1;
    branch_pc = 32'h10;
    ImmOp = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    check("br_valid", instr_valid, 0);
    check("br_addr", imem_addr, 32'h8);
    @(negedge clk);
    check("br_pc", pc_out, 32'h8);
    check("br_instr", instr_out, mem_f(32'h8));

    // JALR redirect while waiting: discard the stale response
    do_reset();
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    redirect = 1'b1;
    redirect_sel = 1'b1;
    alu_result = 32'h101;
    @(negedge clk);
    redirect = 1'b0;
    check("jr_req0", imem_req, 0);
    check("jr_valid", instr_valid, 0);
    check("jr_addr", imem_addr, 32'h100);
    @(negedge clk);
    check("jr_req1", imem_req, 0);
    imem_ready = 1'b1;
    @(negedge clk);
    check("jr_req2", imem_req, 1);
    check("jr_addr2", imem_addr, 32'h100);
    check("jr_drop", instr_valid, 0);
    @(negedge clk);
    check("jr_pc", pc_out, 32'h100);
    check("jr_instr", instr_out, mem_f(32'h100));

    // Random run against the expected instruction stream
    do_reset();
    exp_pc = 32'h0;
    p_hold = 0;
    p_redir = 0;
    p_wait = 0;
    p_instr = '0;
    p_pc = '0;
    p_addr = '0;
    p_tgt = '0;
    idle = 0;
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (p_redir) begin
        check("r_redir_valid", instr_valid, 0);
        check("r_redir_addr", imem_addr, p_tgt);
      end
      if (p_hold) begin
        check("r_hold_valid", instr_valid, 1);
        check("r_hold_pc", pc_out, p_pc);
        check("r_hold_instr", instr_out, p_instr);
      end
      if (p_wait) begin
        check("r_wait_req", imem_req, 1);
        check("r_wait_addr", imem_addr, p_addr);
      end
      stall = ($urandom % 3) == 0;
      redirect = ($urandom % 16) == 0;
      redirect_sel = $urandom % 2;
      branch_pc = $urandom;
      ImmOp = $urandom;
      alu_result = $urandom;
      imem_ready = ($urandom % 4) != 0;
      tgt = redirect_sel ? (alu_result & 32'hFFFF_FFFE)
                         : branch_pc + ImmOp;
      if (redirect) begin
        exp_pc = tgt;
        idle = 0;
      end else if (instr_valid && !stall) begin
        check("r_pc", pc_out, exp_pc);
        check("r_instr", instr_out, mem_f(exp_pc));
        check("r_p4", pc_plus4_out, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 64) begin
        check("r_progress", 32'(idle), 0);
        done = 1;
      end
      p_redir = redirect;
      p_tgt = tgt;
      p_hold = instr_valid && stall && !redirect;
      p_instr = instr_out;
      p_pc = pc_out;
      p_wait = imem_req && !imem_ready && !redirect;
      p_addr = imem_addr;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
